// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-address types and constants for the core
package cpu_pkg;
   typedef logic [3:0] reg_addr_t;

   localparam reg_addr_t REG_SP = 4'd13;
   localparam reg_addr_t REG_LR = 4'd14;
   localparam reg_addr_t REG_PC = 4'd15;

   localparam int PC_READ_OFFSET = 4;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-destination scoreboard with same-cycle bypass-aware busy flags
module reg_scoreboard
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wr_en,
   input  reg_addr_t   i_wr_addr,
   input  logic        i_issue_en,
   input  reg_addr_t   i_issue_addr,
   input  logic        i_flush,
   input  reg_addr_t   i_rd_addr_a,
   input  reg_addr_t   i_rd_addr_b,
   output logic        o_busy_a,
   output logic        o_busy_b,
   output logic [15:0] o_pending
);

   logic [15:0] pending_q;
   logic [15:0] pending_d;

   // Clear before set so a newly issued producer survives its predecessor's write-back.
   always_comb begin
      pending_d = pending_q;
      if (i_flush) begin
         pending_d = '0;
      end else begin
         if (i_wr_en && i_wr_addr != REG_PC) pending_d[i_wr_addr] = 1'b0;
         if (i_issue_en && i_issue_addr != REG_PC) pending_d[i_issue_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   always_comb begin
      o_busy_a = (i_rd_addr_a != REG_PC) && pending_q[i_rd_addr_a]
                 && !(i_wr_en && i_wr_addr == i_rd_addr_a);
      o_busy_b = (i_rd_addr_b != REG_PC) && pending_q[i_rd_addr_b]
                 && !(i_wr_en && i_wr_addr == i_rd_addr_b);
   end

   assign o_pending = pending_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - r0-r14 register file with write-through bypass, PC read and scoreboard
module reg_file
   import cpu_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0400
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [3:0]        i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [3:0]        i_rd_addr_a,
   input  logic [3:0]        i_rd_addr_b,
   output logic [DATA_W-1:0] o_rd_data_a,
   output logic [DATA_W-1:0] o_rd_data_b,
   input  logic [DATA_W-1:0] i_pc,
   input  logic              i_issue_en,
   input  logic [3:0]        i_issue_addr,
   input  logic              i_flush,
   output logic              o_busy_a,
   output logic              o_busy_b,
   output logic [15:0]       o_pending
);

   logic [DATA_W-1:0] regs_q [0:14];
   logic [DATA_W-1:0] regs_d [0:14];
   logic [DATA_W-1:0] pc_read;
   logic              wr_hit;

   assign wr_hit  = i_wr_en && (i_wr_addr != REG_PC);
   assign pc_read = i_pc + DATA_W'(PC_READ_OFFSET);

   always_comb begin
      for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
      if (wr_hit) regs_d[i_wr_addr] = i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++)
            regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end else begin
         for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
      end
   end

   // r15 reads as the Thumb-visible PC; otherwise an in-flight write wins over the array.
   always_comb begin
      if (i_rd_addr_a == REG_PC)                 o_rd_data_a = pc_read;
      else if (wr_hit && i_wr_addr == i_rd_addr_a) o_rd_data_a = i_wr_data;
      else                                       o_rd_data_a = regs_q[i_rd_addr_a];
   end

   always_comb begin
      if (i_rd_addr_b == REG_PC)                 o_rd_data_b = pc_read;
      else if (wr_hit && i_wr_addr == i_rd_addr_b) o_rd_data_b = i_wr_data;
      else                                       o_rd_data_b = regs_q[i_rd_addr_b];
   end

   reg_scoreboard u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .i_wr_en      (i_wr_en),
      .i_wr_addr    (i_wr_addr),
      .i_issue_en   (i_issue_en),
      .i_issue_addr (i_issue_addr),
      .i_flush      (i_flush),
      .i_rd_addr_a  (i_rd_addr_a),
      .i_rd_addr_b  (i_rd_addr_b),
      .o_busy_a     (o_busy_a),
      .o_busy_b     (o_busy_b),
      .o_pending    (o_pending)
   );

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file and write-back scoreboard for the 16-bit-instruction core. It sits directly downstream of the memory-stage control. It takes the write-back request (destination address and write enable, already forced low on stall) plus its data and commits it to r0–r14. It serves two combinational read ports to decode/execute, with write-through bypass. It also tracks pending destination registers so the hazard logic can stall consumers.

## Interface
- `DATA_W`, 32, register and data width
- `SP_RESET`, 32'h0000_0400, reset value of r13 (SP)
- `clk` in 1 — core clock; all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `i_wr_en` in 1 — write-back enable (registered write-enable from memory stage)
- `i_wr_addr` in 4 — write-back destination register
- `i_wr_data` in DATA_W — write-back data
- `i_rd_addr_a` in 4 — read port A address
- `i_rd_addr_b` in 4 — read port B address
- `o_rd_data_a` out DATA_W — read port A data (combinational)
- `o_rd_data_b` out DATA_W — read port B data (combinational)
- `i_pc` in DATA_W — address of instruction currently in decode
- `i_issue_en` in 1 — instruction with a register destination leaves decode this cycle
- `i_issue_addr` in 4 — its destination register
- `i_flush` in 1 — pipeline flush (branch taken); cancels all pending destinations
- `o_busy_a` out 1 — port A register has an uncommitted producer
- `o_busy_b` out 1 — port B register has an uncommitted producer
- `o_pending` out 16 — scoreboard bit vector, bit n = rn pending

## Operation
- Storage: r0–r14 as flops. r15 is not stored; the PC is owned by fetch.
- Reset: r0–r12 and r14 = 0, r13 = SP_RESET, all pending bits = 0. `o_pending` = 0 and `o_busy_a/b` = 0 on the cycle after reset.
- Write: when `i_wr_en` = 1 and `i_wr_addr` != 15, rn <= `i_wr_data` at the edge. Writes to address 15 are dropped silently.
- Read: rn for n = 0..14. Address 15 returns `i_pc` + 4, truncated to DATA_W, matching the Thumb PC-read rule.
- Bypass: if `i_wr_en` = 1 and `i_wr_addr` == read address (not 15), the port returns `i_wr_data` in the same cycle. Applies to both ports independently.
- Scoreboard set: `i_issue_en` = 1 and `i_issue_addr` != 15 sets pending[addr] at the edge.
- Scoreboard clear: `i_wr_en` = 1 and `i_wr_addr` != 15 clears pending[addr] at the edge.
- Same-cycle set and clear on the same address: the set wins, because a newer producer has been issued.
- Flush: `i_flush` = 1 clears all 16 pending bits at the edge. A concurrent issue is ignored. A concurrent write-back still writes data.
- Busy: `o_busy_x` = pending[`i_rd_addr_x`] AND NOT (`i_wr_en` AND `i_wr_addr` == `i_rd_addr_x`), so bypass resolves the hazard in the same cycle. Address 15 is never busy.
- Multiple outstanding issues to one register collapse into one bit. The first write-back clears it. This is acceptable because the in-order pipeline keeps at most one producer in flight past decode per destination.

## Timing
- Write latency: 1 cycle; stored value is visible via the array the cycle after `i_wr_en`, and via bypass in the same cycle.
- Read latency: 0 (combinational from address, `i_pc`, and write port).
- Scoreboard: set/clear visible on `o_pending` one cycle after the qualifying edge; `o_busy_x` combinational on top of it.
- `rst` mid-operation: takes precedence over write, issue and flush in the same cycle. All state returns to its reset values at that edge.
- No handshake back-pressure: the block is always ready; stall is expressed upstream by deasserting `i_wr_en` / `i_issue_en`.

## Structure
- Shared package `cpu_pkg`:
  - `reg_addr_t` (logic[3:0])
  - constants `REG_SP` = 13, `REG_LR` = 14, `REG_PC` = 15
  - `PC_READ_OFFSET` = 4
- Sub-module `reg_scoreboard`:
  - holds the 16-bit pending vector
  - implements set/clear/flush priority and the busy outputs
  - the top level holds the data array, read muxes and bypass

## Test plan
- Reset with SP_RESET = 32'h400: read r13 -> 32'h0000_0400; read r0, r14 -> 0; `o_pending` = 16'h0000.
- Write r3 = 32'hDEAD_BEEF while port A reads r3 in the same cycle -> `o_rd_data_a` = 32'hDEAD_BEEF that cycle and on all later cycles; port B reading r4 -> 0.
- Write to r15 = 32'h1234, `i_pc` = 32'h100; read r15 -> 32'h104; no stored register changes.
- Issue r5, then two idle cycles: `o_pending[5]` = 1 and `o_busy_a` = 1 on r5. In the write-back cycle of r5 = 7, `o_busy_a` = 0 and `o_rd_data_a` = 7; the next cycle `o_pending[5]` = 0.
- Same cycle: issue r2 and write-back r2 -> `o_pending[2]` = 1 afterwards. Then issue r6 together with `i_flush` -> `o_pending` = 0.
- Assert `rst` in the same cycle as writing r1 = 9 and issuing r1 -> r1 = 0 and `o_pending` = 0 afterwards.
